// File: rtl/md_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, latencies
// and the controller state encoding.
package md_ctrl_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'b000,
      MD_MULTU = 3'b001,
      MD_DIV   = 3'b010,
      MD_DIVU  = 3'b011,
      MD_MTHI  = 3'b100,
      MD_MTLO  = 3'b101
   } md_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } md_state_e;

   localparam logic [3:0] MULT_CYCLES = 4'd5;
   localparam logic [3:0] DIV_CYCLES  = 4'd10;

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_mult_op(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit result generator for mult/multu/div/divu, working on
// the operands latched by md_ctrl.
module md_calc
   import md_ctrl_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi_res,
   output logic [31:0] lo_res,
   output logic        div0
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        sgn;
   logic [31:0] dvd;
   logic [31:0] dsr;
   logic [31:0] dsr_safe;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign prod_u = {32'd0, a} * {32'd0, b};

   // Signed division runs on magnitudes so that 0x80000000 / -1 needs no
   // special case and never overflows the divider.
   assign sgn      = (op == MD_DIV);
   assign dvd      = (sgn && a[31]) ? (32'd0 - a) : a;
   assign dsr      = (sgn && b[31]) ? (32'd0 - b) : b;
   assign dsr_safe = (dsr == 32'd0) ? 32'd1 : dsr;
   assign quo      = dvd / dsr_safe;
   assign rem      = dvd % dsr_safe;
   assign quo_fix  = (sgn && (a[31] ^ b[31])) ? (32'd0 - quo) : quo;
   assign rem_fix  = (sgn && a[31]) ? (32'd0 - rem) : rem;

   always_comb begin
      hi_res = 32'd0;
      lo_res = 32'd0;
      div0   = 1'b0;
      case (op)
         MD_MULT: begin
            hi_res = prod_s[63:32];
            lo_res = prod_s[31:0];
         end
         MD_MULTU: begin
            hi_res = prod_u[63:32];
            lo_res = prod_u[31:0];
         end
         MD_DIV, MD_DIVU: begin
            hi_res = rem_fix;
            lo_res = quo_fix;
            div0   = (b == 32'd0);
         end
         default: begin
            hi_res = 32'd0;
            lo_res = 32'd0;
            div0   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide unit controller: IDLE/RUN FSM, cycle counter, HI/LO
// registers and the D-stage stall request.
module md_ctrl
   import md_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        md_D,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        stall_md
);

   md_state_e   state;
   logic [3:0]  cnt;
   logic [2:0]  op_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] hi_res;
   logic [31:0] lo_res;
   logic        div0;

   md_calc u_calc (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .hi_res (hi_res),
      .lo_res (lo_res),
      .div0   (div0)
   );

   assign busy     = (state == RUN);
   assign stall_md = md_D && (start || busy);

   // FSM, counter, operand latches and HI/LO; new starts are ignored in RUN.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
         op_q  <= 3'd0;
         a_q   <= 32'd0;
         b_q   <= 32'd0;
         HI    <= 32'd0;
         LO    <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  case (op)
                     MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                        op_q  <= op;
                        a_q   <= A;
                        b_q   <= B;
                        cnt   <= is_div_op(op) ? DIV_CYCLES : MULT_CYCLES;
                        state <= RUN;
                     end
                     MD_MTHI: HI <= A;
                     MD_MTLO: LO <= A;
                     default: begin
                        state <= IDLE;
                     end
                  endcase
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               if (cnt == 4'd1) begin
                  if (!div0) begin
                     HI <= hi_res;
                     LO <= lo_res;
                  end else begin
                     HI <= HI;
                     LO <= LO;
                  end
                  cnt   <= 4'd0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed self-checking bench for md_ctrl with hand-computed HI/LO values.
module tb_md_ctrl;
   import md_ctrl_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        md_D;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        stall_md;

   int checks = 0;
   int errors = 0;

   md_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .A        (A),
      .B        (B),
      .md_D     (md_D),
      .busy     (busy),
      .HI       (HI),
      .LO       (LO),
      .stall_md (stall_md)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op, scramble operands after the start edge, count busy cycles
   // and stall cycles, then compare HI/LO.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int n,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int cyc;
      int stalls;
      @(negedge clk);
      start = 1'b1; op = o; A = a; B = b;
      @(negedge clk);
      start = 1'b0; A = 32'hDEADBEEF; B = 32'h0BADF00D;
      cyc = 0;
      stalls = 0;
      while (busy && cyc < 30) begin
         cyc++;
         if (stall_md) stalls++;
         @(negedge clk);
      end
      chk_eq({tag, "_busy_cycles"}, 32'(cyc), 32'(n));
      chk_eq({tag, "_stall_cycles"}, 32'(stalls), md_D ? 32'(n) : 32'd0);
      chk_eq({tag, "_hi"}, HI, exp_hi);
      chk_eq({tag, "_lo"}, LO, exp_lo);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 3'd0; A = 32'd0; B = 32'd0; md_D = 1'b0;
      #12;
      chk_eq("reset_busy", {31'd0, busy}, 32'd0);
      chk_eq("reset_hi", HI, 32'd0);
      chk_eq("reset_lo", LO, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      run_op("mult", MD_MULT, 32'hFFFFFFFD, 32'd7, 5, 32'hFFFFFFFF, 32'hFFFFFFEB);

      md_D = 1'b1;
      @(negedge clk);
      start = 1'b1; op = MD_MTHI; A = HI;
      #1 chk_eq("stall_on_start", {31'd0, stall_md}, 32'd1);
      start = 1'b0;
      run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
      md_D = 1'b0;
      #1 chk_eq("stall_idle", {31'd0, stall_md}, 32'd0);

      run_op("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("divu_by0", MD_DIVU, 32'd7, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
      run_op("divu", MD_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);
      run_op("div_negb", MD_DIV, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD);

      // mthi then mtlo on successive edges, never busy
      @(negedge clk);
      start = 1'b1; op = MD_MTHI; A = 32'h12345678;
      @(negedge clk);
      chk_eq("mthi_hi", HI, 32'h12345678);
      chk_eq("mthi_busy", {31'd0, busy}, 32'd0);
      op = MD_MTLO; A = 32'h9ABCDEF0;
      @(negedge clk);
      start = 1'b0;
      chk_eq("mtlo_lo", LO, 32'h9ABCDEF0);
      chk_eq("mtlo_hi", HI, 32'h12345678);
      chk_eq("mtlo_busy", {31'd0, busy}, 32'd0);

      // reserved op is a no-op
      start = 1'b1; op = 3'b110; A = 32'h55555555;
      @(negedge clk);
      start = 1'b0;
      chk_eq("rsvd_busy", {31'd0, busy}, 32'd0);
      chk_eq("rsvd_hi", HI, 32'h12345678);
      chk_eq("rsvd_lo", LO, 32'h9ABCDEF0);

      // second mult while busy is ignored
      start = 1'b1; op = MD_MULT; A = 32'd3; B = 32'd5;
      @(negedge clk);
      op = MD_MTHI; A = 32'd100; B = 32'd100;
      @(negedge clk);
      op = MD_MULT;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk_eq("ignore_busy_done", {31'd0, busy}, 32'd0);
      chk_eq("ignore_hi", HI, 32'd0);
      chk_eq("ignore_lo", LO, 32'd15);

      // async reset in the middle of a div
      @(negedge clk);
      start = 1'b1; op = MD_DIV; A = 32'hFFFFFFF9; B = 32'd2;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk_eq("arst_busy", {31'd0, busy}, 32'd0);
      chk_eq("arst_hi", HI, 32'd0);
      chk_eq("arst_lo", LO, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_op("post_reset", MD_MULT, 32'd3, 32'd4, 5, 32'd0, 32'd12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
